// File: rtl/deint_pkg.sv
// deint_pkg: default geometry of the convolutional deinterleaver shared by RTL and bench.
package deint_pkg;
  localparam int BRANCHES = 12;
  localparam int DEPTH_UNIT = 17;
  localparam int DATA_W = 8;
  localparam int TOTAL_LAT_BYTES = (BRANCHES - 1) * DEPTH_UNIT * BRANCHES;
endpackage

// File: rtl/deint_delay_line.sv
// deint_delay_line: enable-gated shift register; q is the oldest stage, valid before the shift.
module deint_delay_line #(
  parameter int LEN = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] sr_q [LEN];
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < LEN; i++) sr_q[i] <= '0;
    end else if (en) begin
      sr_q[0] <= d;
      for (int i = 1; i < LEN; i++) sr_q[i] <= sr_q[i-1];
    end
  assign q = sr_q[LEN-1];
endmodule

// File: rtl/conv_deinterleaver.sv
// conv_deinterleaver: Forney deinterleaver; branch j delays (B-1-j)*M visits, last branch is direct.
module conv_deinterleaver #(
  parameter int BRANCHES = deint_pkg::BRANCHES,
  parameter int DEPTH_UNIT = deint_pkg::DEPTH_UNIT,
  parameter int DATA_W = deint_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        sync_in,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           data_out,
  output logic                        sync_out,
  output logic [$clog2(BRANCHES)-1:0] branch_idx
);
  localparam int CW = $clog2(BRANCHES);
  logic [CW-1:0] cnt_q, cnt_d, sel;
  logic [DATA_W-1:0] br_q [BRANCHES];
  // a sync byte always realigns the commutator to branch 0
  assign sel = sync_in ? '0 : cnt_q;
  assign cnt_d = (sel == CW'(BRANCHES - 1)) ? '0 : sel + 1'b1;
  for (genvar j = 0; j < BRANCHES - 1; j++) begin : g_br
    deint_delay_line #(.LEN((BRANCHES - 1 - j) * DEPTH_UNIT), .DATA_W(DATA_W)) u_dl (
      .clk(clk),
      .reset(reset),
      .en(in_valid && sel == CW'(j)),
      .d(data_in),
      .q(br_q[j])
    );
  end
  assign br_q[BRANCHES-1] = data_in;
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      out_valid <= 1'b0;
      data_out <= '0;
      sync_out <= 1'b0;
      branch_idx <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        cnt_q <= cnt_d;
        data_out <= br_q[sel];
        branch_idx <= sel;
        sync_out <= sync_in;
      end
    end
endmodule

// File: tb/tb_conv_deinterleaver.sv
// tb_conv_deinterleaver: random and directed stimulus against a per-branch FIFO model and an interleaver loopback.
module tb_conv_deinterleaver;
  localparam int B = deint_pkg::BRANCHES;
  localparam int M = deint_pkg::DEPTH_UNIT;
  localparam int LAT = deint_pkg::TOTAL_LAT_BYTES;
  logic clk = 1'b0;
  logic reset, in_valid, sync_in, out_valid, sync_out;
  logic [7:0] data_in, data_out;
  logic [$clog2(B)-1:0] branch_idx;
  int checks = 0, failures = 0;
  logic [7:0] mq [B][$];
  logic [7:0] iq [B][$];
  int mcnt, icnt, n_acc, n_out;
  logic ev, es;
  logic [7:0] ed;
  int eb;

  conv_deinterleaver dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .sync_in(sync_in),
    .out_valid(out_valid), .data_out(data_out), .sync_out(sync_out), .branch_idx(branch_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < B; j++) begin
      mq[j].delete();
      iq[j].delete();
      repeat ((B - 1 - j) * M) mq[j].push_back(8'h00);
      repeat (j * M) iq[j].push_back(8'h00);
    end
    mcnt = 0;
    icnt = 0;
    n_acc = 0;
    n_out = 0;
    ev = 0; ed = 0; eb = 0; es = 0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit r);
    int sel;
    reset = r; in_valid = v; data_in = d; sync_in = s;
    if (r) model_reset();
    else begin
      ev = v;
      if (v) begin
        sel = s ? 0 : mcnt;
        mq[sel].push_back(d);
        ed = mq[sel].pop_front();
        eb = sel;
        es = s;
        mcnt = (sel == B - 1) ? 0 : sel + 1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    if (out_valid) n_out++;
    chk("out_valid", out_valid, ev);
    chk("data_out", data_out, ed);
    chk("branch_idx", branch_idx, eb);
    chk("sync_out", sync_out, es);
  endtask

  task automatic loopback(input bit gaps);
    logic [7:0] x;
    step(1, 8'hFF, 0, 1);
    for (int k = 0; k < LAT + 300; k++) begin
      while (gaps && $urandom_range(0, 3) == 0) step(0, 8'($urandom), 0, 0);
      iq[icnt].push_back(8'(k));
      x = iq[icnt].pop_front();
      step(1, x, icnt == 0, 0);
      icnt = (icnt == B - 1) ? 0 : icnt + 1;
      if (k >= LAT) chk(gaps ? "loop_gaps" : "loop", data_out, 32'((k - LAT) & 255));
    end
  endtask

  initial begin
    repeat (3) step(1, 8'hFF, 0, 1);
    repeat (11) step(1, 8'h00, 0, 0);
    step(1, 8'hA5, 0, 0);
    chk("pass_data", data_out, 8'hA5);
    chk("pass_idx", branch_idx, 11);
    step(1, 8'h00, 0, 1);
    step(1, 8'h3C, 0, 0);
    chk("b0_first_idx", branch_idx, 0);
    for (int k = 0; k < LAT; k++) step(1, 8'($urandom_range(0, 255) | 1), 0, 0);
    chk("b0_depth_data", data_out, 8'h3C);
    chk("b0_depth_idx", branch_idx, 0);
    step(1, 8'h00, 0, 1);
    repeat (5) step(1, 8'($urandom), 0, 0);
    step(1, 8'h77, 1, 0);
    chk("resync_idx0", branch_idx, 0);
    chk("resync_sync", sync_out, 1);
    step(1, 8'h78, 0, 0);
    chk("resync_idx1", branch_idx, 1);
    while (n_acc < 1000) step($urandom_range(0, 4) != 0, 8'($urandom), $urandom_range(0, 30) == 0, 0);
    chk("count", n_out, n_acc);
    step(1, 8'h5A, 1, 1);
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_data", data_out, 0);
    for (int k = 0; k < 400; k++) step($urandom_range(0, 5) != 0, 8'($urandom), 0, 0);
    loopback(0);
    loopback(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
